// File: rtl/gcd_wb_bridge.sv
// rtl/gcd_wb_bridge.sv - Wishbone register bridge to a GCD unit; optional irq via GCD_WB_BRIDGE_IRQ_EN
module gcd_wb_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] gcd_req_msg,
    output logic        gcd_req_val,
    input  logic        gcd_req_rdy,
    input  logic [15:0] gcd_resp_msg,
    input  logic        gcd_resp_val,
    output logic        gcd_resp_rdy,
    output logic        irq_o
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    localparam logic [1:0] OFF_OPERANDS = 2'd0;
    localparam logic [1:0] OFF_RESULT   = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_CONTROL  = 2'd3;

    logic          ack_q;
    logic [31:0]   dat_q;
    logic          req_pending;
    logic [31:0]   req_reg;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    count;
    logic          irq_en;
    logic [31:0]   rd_data;

    // Byte-lane address bits carry no meaning for word registers.
    logic unused_adr_bits;
    assign unused_adr_bits = ^wbs_adr_i[1:0];

    logic [1:0] off;
    logic       hit, op_stall, access, wr_en, rd_en;
    logic       op_load, ctl_wr, flush, push, pop;
    logic       fifo_full, fifo_empty;

    assign off        = wbs_adr_i[3:2];
    assign hit        = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // An operand write must not overwrite a request the GCD unit has not taken yet.
    assign op_stall   = wbs_we_i && (off == OFF_OPERANDS) && req_pending;
    // ack_q blocks a second action while the master still holds the acked strobe.
    assign access     = hit && !ack_q && !op_stall;
    assign wr_en      = access && wbs_we_i;
    assign rd_en      = access && !wbs_we_i;
    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == 5'd0);
    assign op_load    = wr_en && (off == OFF_OPERANDS) && (wbs_sel_i == 4'hF);
    assign ctl_wr     = wr_en && (off == OFF_CONTROL) && wbs_sel_i[0];
    assign flush      = ctl_wr && wbs_dat_i[0];
    // A response arriving with a flush is still handshaken, then dropped.
    assign push       = gcd_resp_val && gcd_resp_rdy && !flush;
    assign pop        = rd_en && (off == OFF_RESULT) && !fifo_empty;

    assign gcd_resp_rdy = !fifo_full;
    assign gcd_req_val  = req_pending;
    assign gcd_req_msg  = req_reg;
    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;

    // Bus acknowledge and registered read data, both one cycle after the hit.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
        end else begin
            ack_q <= access;
            if (rd_en) begin
                dat_q <= rd_data;
            end
        end
    end

    // Request register: loaded by a full-word operand write, released on handshake.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            req_pending <= 1'b0;
            req_reg     <= 32'h0;
        end else if (op_load) begin
            req_pending <= 1'b1;
            req_reg     <= wbs_dat_i;
        end else if (req_pending && gcd_req_rdy) begin
            req_pending <= 1'b0;
        end
    end

    // Response FIFO; pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 16'h0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= gcd_resp_msg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Register read multiplexer.
    always_comb begin
        rd_data = 32'h0;
        case (off)
            OFF_OPERANDS: rd_data = req_reg;
            OFF_RESULT:   rd_data = fifo_empty ? 32'h0 : {1'b1, 15'b0, mem[rd_ptr]};
            OFF_STATUS:   rd_data = {23'b0, count, 1'b0, fifo_full, fifo_empty, req_pending};
            default:      rd_data = {30'b0, irq_en, 1'b0};
        endcase
    end

`ifdef GCD_WB_BRIDGE_IRQ_EN
    logic irq_q;

    // Interrupt enable and registered result-available interrupt.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (ctl_wr) begin
                irq_en <= wbs_dat_i[1];
            end
            irq_q <= irq_en && !fifo_empty;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_wb_bridge.sv
// tb/tb_gcd_wb_bridge.sv - directed self-checking bench for gcd_wb_bridge
module tb_gcd_wb_bridge;

    localparam logic [31:0] A_OPS = 32'h3000_0000;
    localparam logic [31:0] A_RES = 32'h3000_0004;
    localparam logic [31:0] A_STA = 32'h3000_0008;
    localparam logic [31:0] A_CTL = 32'h3000_000C;
`ifdef GCD_WB_BRIDGE_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] req_msg;
    logic        req_val, req_rdy;
    logic [15:0] resp_msg;
    logic        resp_val, resp_rdy;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rd_a;
    logic        ack_a;
    int          lat_a;

    gcd_wb_bridge dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .gcd_req_msg  (req_msg),
        .gcd_req_val  (req_val),
        .gcd_req_rdy  (req_rdy),
        .gcd_resp_msg (resp_msg),
        .gcd_resp_val (resp_val),
        .gcd_resp_rdy (resp_rdy),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int budget,
                        output logic [31:0] rd, output logic acked, output int lat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        acked = 1'b0;
        rd    = 32'hDEAD_BEEF;
        lat   = 0;
        for (int i = 0; i < budget && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                rd    = rdat;
                lat   = i + 1;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        k;
        int          l;
        xfer(1'b0, a, 4'hF, 32'h0, 10, d, k, l);
        check(tag, d, exp);
    endtask

    task automatic wr_reg(input string tag, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
        logic [31:0] r;
        logic        k;
        int          l;
        xfer(1'b1, a, s, d, 10, r, k, l);
        check(tag, {31'b0, k}, 32'h1);
    endtask

    task automatic send_resp(input logic [15:0] m);
        @(posedge clk); #1;
        resp_val = 1'b1; resp_msg = m;
        @(posedge clk); #1;
        resp_val = 1'b0;
    endtask

    task automatic take_req();
        @(posedge clk); #1;
        req_rdy = 1'b1;
        @(posedge clk); #1;
        req_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; wdat = 32'h0; req_rdy = 1'b0; resp_val = 1'b0; resp_msg = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_req_val", {31'b0, req_val}, 32'h0);
        check("rst_resp_rdy", {31'b0, resp_rdy}, 32'h1);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rd_reg("rst_status", A_STA, 32'h0000_0002);

        // Single request / response
        wr_reg("ops_wr_ack", A_OPS, 4'hF, 32'h0030_0012);
        check("req_val_set", {31'b0, req_val}, 32'h1);
        check("req_msg", req_msg, 32'h0030_0012);
        rd_reg("status_pending", A_STA, 32'h0000_0003);
        rd_reg("ops_readback", A_OPS, 32'h0030_0012);
        take_req();
        check("req_val_clr", {31'b0, req_val}, 32'h0);
        send_resp(16'd6);
        rd_reg("status_one", A_STA, 32'h0000_0010);
        rd_reg("result_6", A_RES, 32'h8000_0006);
        rd_reg("status_empty", A_STA, 32'h0000_0002);

        // Partial-select operand write and writes to read-only registers are ignored
        wr_reg("ops_partial_ack", A_OPS, 4'h3, 32'h0000_DEAD);
        check("partial_no_req", {31'b0, req_val}, 32'h0);
        rd_reg("partial_ops", A_OPS, 32'h0030_0012);
        wr_reg("status_wr_ack", A_STA, 4'hF, 32'hFFFF_FFFF);
        rd_reg("status_wr_ign", A_STA, 32'h0000_0002);

        // Address outside the window
        xfer(1'b0, 32'h4000_0008, 4'hF, 32'h0, 5, rd_a, ack_a, lat_a);
        check("miss_no_ack", {31'b0, ack_a}, 32'h0);

        // Stalled operand write
        wr_reg("stall_first_ack", A_OPS, 4'hF, 32'h0001_0001);
        fork
            xfer(1'b1, A_OPS, 4'hF, 32'h0002_0002, 40, rd_a, ack_a, lat_a);
            begin
                repeat (6) @(posedge clk);
                #2;
                check("stall_no_ack", {31'b0, ack}, 32'h0);
                check("stall_msg_hold", req_msg, 32'h0001_0001);
                req_rdy = 1'b1;
                @(posedge clk); #1;
                req_rdy = 1'b0;
            end
        join
        check("stall_acked", {31'b0, ack_a}, 32'h1);
        check("stall_latency", lat_a, 32'd7);
        check("stall_req_val", {31'b0, req_val}, 32'h1);
        check("stall_next_msg", req_msg, 32'h0002_0002);
        take_req();
        check("stall_done", {31'b0, req_val}, 32'h0);

        // Fill the FIFO, try overfill, drain in order
        send_resp(16'd1);
        send_resp(16'd2);
        send_resp(16'd3);
        send_resp(16'd4);
        check("full_rdy", {31'b0, resp_rdy}, 32'h0);
        rd_reg("full_status", A_STA, 32'h0000_0044);
        send_resp(16'd5);
        rd_reg("overfill_status", A_STA, 32'h0000_0044);
        rd_reg("pop_1", A_RES, 32'h8000_0001);
        rd_reg("pop_2", A_RES, 32'h8000_0002);
        rd_reg("pop_3", A_RES, 32'h8000_0003);
        rd_reg("pop_4", A_RES, 32'h8000_0004);
        rd_reg("pop_empty", A_RES, 32'h0000_0000);
        rd_reg("drained_status", A_STA, 32'h0000_0002);

        // Simultaneous push and pop at count 2 (pointers have wrapped)
        send_resp(16'd7);
        send_resp(16'd8);
        fork
            xfer(1'b0, A_RES, 4'hF, 32'h0, 10, rd_a, ack_a, lat_a);
            begin
                @(posedge clk); #1;
                resp_val = 1'b1; resp_msg = 16'd9;
                @(posedge clk); #1;
                resp_val = 1'b0;
            end
        join
        check("pushpop_data", rd_a, 32'h8000_0007);
        rd_reg("pushpop_status", A_STA, 32'h0000_0020);
        rd_reg("pushpop_8", A_RES, 32'h8000_0008);
        rd_reg("pushpop_9", A_RES, 32'h8000_0009);

        // Flush concurrent with a push, then interrupt behaviour
        send_resp(16'd5);
        fork
            xfer(1'b1, A_CTL, 4'hF, 32'h0000_0003, 10, rd_a, ack_a, lat_a);
            begin
                @(posedge clk); #1;
                resp_val = 1'b1; resp_msg = 16'hA;
                @(posedge clk); #1;
                resp_val = 1'b0;
            end
        join
        check("flush_ack", {31'b0, ack_a}, 32'h1);
        rd_reg("flush_status", A_STA, 32'h0000_0002);
        rd_reg("ctl_read", A_CTL, {30'b0, IRQ_ON, 1'b0});
        check("irq_idle", {31'b0, irq}, 32'h0);
        send_resp(16'hB);
        @(posedge clk); #1;
        check("irq_rise", {31'b0, irq}, {31'b0, IRQ_ON});
        rd_reg("flush_result", A_RES, 32'h8000_000B);
        @(posedge clk); #1;
        check("irq_fall", {31'b0, irq}, 32'h0);
        wr_reg("ctl_clear", A_CTL, 4'hF, 32'h0);

        // Reset during a stalled operand write
        wr_reg("rst_op1_ack", A_OPS, 4'hF, 32'h0005_0005);
        fork
            xfer(1'b1, A_OPS, 4'hF, 32'h0006_0006, 5, rd_a, ack_a, lat_a);
            begin
                repeat (3) @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("rst_req_val_now", {31'b0, req_val}, 32'h0);
                check("rst_ack_now", {31'b0, ack}, 32'h0);
                check("rst_resp_rdy_now", {31'b0, resp_rdy}, 32'h1);
                repeat (4) @(posedge clk);
                #2 rst_n = 1'b1;
            end
        join
        check("rst_stall_no_ack", {31'b0, ack_a}, 32'h0);
        rd_reg("rst_status_after", A_STA, 32'h0000_0002);
        rd_reg("rst_ops_after", A_OPS, 32'h0000_0000);
        check("rst_req_msg_after", req_msg, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
